instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock, clk, with all state updated on its rising edge.
REQ-002 The block SHALL use reset rst, asynchronous and active-high.
REQ-003 Ports SHALL be exactly as listed, one per line: name, direction, width, meaning.
  clk  in  1  system clock
  rst  in  1  async active-high reset
  stall  in  1  decode holds current instruction
  redirect  in  1  branch/call/ret taken; flush and refetch
  redirect_pc  in  16  new fetch address
  imem_rd_en  out  1  one-cycle read request pulse
  imem_addr  out  16  read address, valid with imem_rd_en
  imem_rdata  in  16  instruction word, valid with imem_ready
  imem_ready  in  1  response for outstanding request, latency >=1 cycle
  instr  out  16  instruction to decode
  opcode  out  4  instr[15:12]
  pc_plus1  out  16  address of instr + 1, modulo 2^16
  instr_valid  out  1  instr/opcode/pc_plus1 valid
  halted  out  1  fetch stopped on opcode 4'b1111

Function
REQ-004 The FSM SHALL have states FETCH, WAIT, DRAIN and HALT.
REQ-005 FETCH: if the output slot is free or being consumed (!instr_valid || !stall) and redirect=0, assert imem_rd_en=1 and imem_addr=pc for one cycle, then go to WAIT; otherwise issue nothing and stay in FETCH.
REQ-006 WAIT, imem_ready=1, redirect=0: load instr<=imem_rdata, set pc_plus1<=pc+1, set instr_valid<=1, set pc<=pc+1.
REQ-007 On the REQ-006 capture, the next state SHALL be HALT if imem_rdata[15:12]=4'b1111, else FETCH.
REQ-008 WAIT, redirect=1: the response SHALL be discarded; if imem_ready=1 that cycle, go to FETCH; otherwise go to DRAIN.
REQ-009 DRAIN: remain until imem_ready=1, discard that data, then go to FETCH.
REQ-010 A redirect while in DRAIN SHALL only update the target pc, with the latest redirect_pc winning.
REQ-011 Any cycle with redirect=1 SHALL set pc<=redirect_pc and clear instr_valid next cycle, regardless of stall; redirect has priority over capture and issue.
REQ-012 Redirect in FETCH SHALL suppress imem_rd_en that cycle.
REQ-013 Redirect in HALT SHALL go to FETCH and clear halted.
REQ-014 HALT: halted=1; no imem_rd_en; pc frozen; the halting instruction SHALL be presented once with normal stall semantics; only redirect or rst exits HALT.
REQ-015 stall=1 with instr_valid=1 SHALL hold instr, opcode and pc_plus1 unchanged.
REQ-016 stall=0 with instr_valid=1 and no capture that cycle SHALL clear instr_valid (consumed).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 imem_ready outside WAIT/DRAIN SHALL be ignored.
REQ-019 pc SHALL wrap 16'hFFFF -> 16'h0000 without a flag.
REQ-020 Steady-state throughput SHALL be one instruction per 2 cycles at imem latency 1.
REQ-021 opcode SHALL always equal instr[15:12].

Reset
REQ-022 While rst=1, outputs SHALL be: pc=16'h0000, state=FETCH, instr=16'h0000, opcode=4'h0, pc_plus1=16'h0000, instr_valid=0, halted=0, imem_rd_en=0.
REQ-023 The first request after rst deasserts SHALL be imem_addr=16'h0000.
REQ-024 rst mid-WAIT or mid-DRAIN SHALL abandon the outstanding request.
REQ-025 A stale imem_ready arriving after reset in FETCH SHALL be ignored.

Verification
REQ-026 Sequential fetch: latency-1 memory returning addr+16'h1000, stall=0 -> instr 16'h1000, 16'h1001, 16'h1002 with pc_plus1 1, 2, 3; imem_rd_en every second cycle.
REQ-027 Stall hold: stall=1 for 4 cycles while instr=16'h1001 -> instr, pc_plus1 and instr_valid held; no imem_rd_en issued; resumes at address 2 after release.
REQ-028 Redirect during WAIT: redirect=1, redirect_pc=16'h0040 with latency-3 memory -> old data discarded, instr_valid never 1 for it, next imem_addr=16'h0040.
REQ-029 Halt: memory returns 16'hF000 at address 5 -> instr_valid=1 with opcode 4'hF, then halted=1; no further requests for 10 cycles; redirect to 16'h0010 resumes fetch at 16'h0010.
REQ-030 Wrap: redirect to 16'hFFFF -> fetch 16'hFFFF with pc_plus1=16'h0000, next imem_addr=16'h0000.
REQ-031 Reset mid-operation: assert rst while in DRAIN -> all outputs at reset values immediately; stale imem_ready ignored; first fetch at 16'h0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-outstanding reads to instruction memory,
// buffers one instruction for decode, handles redirect/flush and halt on opcode 4'hF.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] pc_plus1,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OPC_HALT = 4'hF;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic        slot_free;
  logic        issue;
  logic        capture;

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    slot_free = !instr_valid || !stall;
    unique case (state)
      FETCH: begin
        if (!redirect && slot_free) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready) begin
          capture   = 1'b1;
          state_nxt = (imem_rdata[15:12] == OPC_HALT) ? HALT : FETCH;
        end
      end
      DRAIN: begin
        // The in-flight response must be absorbed before a new request may go out.
        if (imem_ready) state_nxt = FETCH;
      end
      HALT: begin
        if (redirect) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously, so the request strobe is masked while rst is held.
  assign imem_rd_en = issue && !rst;
  assign imem_addr  = pc;
  assign opcode     = instr[15:12];
  assign halted     = (state == HALT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= 16'h0000;
      instr       <= 16'h0000;
      pc_plus1    <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc          <= redirect_pc;
        instr_valid <= 1'b0;
      end else if (capture) begin
        instr       <= imem_rdata;
        pc_plus1    <= pc + 16'd1;
        pc          <= pc + 16'd1;
        instr_valid <= 1'b1;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model with programmable latency,
// a scoreboard of expected instructions, a vector table and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_plus1;
  logic        instr_valid;
  logic        halted;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .opcode      (opcode),
    .pc_plus1    (pc_plus1),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic        stale;
  } req_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pp;
  } exp_t;

  typedef struct {
    logic        s;
    logic        rd;
    logic [15:0] addr;
    logic        v;
    logic [15:0] ins;
    logic [15:0] pp;
  } vec_t;

  req_t mq[$];
  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   lat;
  logic halt_mode;
  logic prev_valid;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_mode && a == 16'h0005) return 16'hF000;
    return a + 16'h1000;
  endfunction

  task automatic push_exp(input logic [15:0] ins, input logic [15:0] pp);
    exp_t e;
    e.ins = ins;
    e.pp  = pp;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs and the memory response at negedge, then sample mid-cycle.
  task automatic step(input logic r_in, input logic s_in, input logic rd_in, input logic [15:0] rpc_in);
    req_t rq;
    exp_t e;
    int   live;
    @(negedge clk);
    rst         = r_in;
    stall       = s_in;
    redirect    = rd_in;
    redirect_pc = rpc_in;
    imem_ready  = 1'b0;
    imem_rdata  = 16'hDEAD;
    if (r_in) foreach (mq[i]) mq[i].stale = 1'b1;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (imem_rd_en) begin
      live = 0;
      foreach (mq[i]) if (!mq[i].stale) live++;
      check("single_outstanding", 16'(live), 16'd0);
      rq.due   = cyc + lat;
      rq.addr  = imem_addr;
      rq.stale = 1'b0;
      mq.push_back(rq);
    end
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got %h, expected no instruction (cycle %0d)", instr, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instr, e.ins);
        check("sb_pc_plus1", pc_plus1, e.pp);
        check("sb_opcode", {12'h000, opcode}, {12'h000, e.ins[15:12]});
      end
    end
    prev_valid = instr_valid;
    cyc++;
  endtask

  task automatic expect_io(input string name, input logic rd, input logic [15:0] addr,
                           input logic v, input logic h);
    check({name, "_rd_en"}, {15'h0, imem_rd_en}, {15'h0, rd});
    if (rd) check({name, "_addr"}, imem_addr, addr);
    check({name, "_valid"}, {15'h0, instr_valid}, {15'h0, v});
    check({name, "_halted"}, {15'h0, halted}, {15'h0, h});
  endtask

  task automatic check_reset(input string name);
    check({name, "_instr"}, instr, 16'h0000);
    check({name, "_opcode"}, {12'h000, opcode}, 16'h0000);
    check({name, "_pc_plus1"}, pc_plus1, 16'h0000);
    check({name, "_pc"}, imem_addr, 16'h0000);
    check({name, "_valid"}, {15'h0, instr_valid}, 16'h0000);
    check({name, "_halted"}, {15'h0, halted}, 16'h0000);
    check({name, "_rd_en"}, {15'h0, imem_rd_en}, 16'h0000);
  endtask

  vec_t vecs[14];

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    lat         = 1;
    halt_mode   = 1'b0;
    prev_valid  = 1'b0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready  = 1'b0;
    imem_rdata  = 16'h0000;

    // Sequential fetch at latency 1, with a 4-cycle stall holding instruction 16'h1001.
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0001};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0002};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0002};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0002};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0002};
    vecs[8]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h1001, 16'h0002};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h1002, 16'h0003};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h1003, 16'h0004};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};

    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check_reset("rst_hold0");
    step(1'b1, 1'b0, 1'b1, 16'h0077);
    check_reset("rst_hold1");

    push_exp(16'h1000, 16'h0001);
    push_exp(16'h1001, 16'h0002);
    push_exp(16'h1002, 16'h0003);
    push_exp(16'h1003, 16'h0004);
    push_exp(16'h1004, 16'h0005);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, vecs[i].s, 1'b0, 16'h0000);
      expect_io($sformatf("seq%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].v, 1'b0);
      if (vecs[i].v) begin
        check($sformatf("seq%0d_instr", i), instr, vecs[i].ins);
        check($sformatf("seq%0d_pc_plus1", i), pc_plus1, vecs[i].pp);
      end
    end

    // Halt on opcode F at address 5, presented with normal stall semantics.
    halt_mode = 1'b1;
    push_exp(16'hF000, 16'h0006);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("h_issue", 1'b1, 16'h0005, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("h_wait", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000); expect_io("h_present", 1'b0, 16'h0000, 1'b1, 1'b1);
    check("h_opcode", {12'h000, opcode}, 16'h000F);
    step(1'b0, 1'b1, 1'b0, 16'h0000); expect_io("h_stall", 1'b0, 16'h0000, 1'b1, 1'b1);
    check("h_stall_instr", instr, 16'hF000);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("h_consume", 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      expect_io($sformatf("h_idle%0d", i), 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    push_exp(16'h1010, 16'h0011);
    step(1'b0, 1'b0, 1'b1, 16'h0010); expect_io("h_redirect", 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("h_resume", 1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("h_resume_wait", 1'b0, 16'h0000, 1'b0, 1'b0);

    // Redirect during WAIT at latency 3, then a second redirect while draining; latest target wins.
    lat = 3;
    push_exp(16'h1040, 16'h0041);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("d_issue", 1'b1, 16'h0011, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0030); expect_io("d_wait_redirect", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0040); expect_io("d_drain_redirect", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("d_drain_ready", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("d_refetch", 1'b1, 16'h0040, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      expect_io($sformatf("d_lat%0d", i), 1'b0, 16'h0000, 1'b0, 1'b0);
    end

    // Wrap: redirect to 16'hFFFF suppresses the issue that cycle; the next fetch wraps to 0.
    lat = 1;
    push_exp(16'h0FFF, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'hFFFF); expect_io("w_redirect", 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("w_issue", 1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("w_wait", 1'b0, 16'h0000, 1'b0, 1'b0);
    lat = 4;
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("w_wrap_issue", 1'b1, 16'h0000, 1'b1, 1'b0);

    // Reset while draining: outputs clear at once and the stale response lands in FETCH.
    push_exp(16'h1000, 16'h0001);
    step(1'b0, 1'b0, 1'b1, 16'h1234); expect_io("r_wait_redirect", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000); check_reset("r_rst_drain");
    step(1'b1, 1'b0, 1'b0, 16'h0000); check_reset("r_rst_hold");
    lat = 1;
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("r_first_fetch", 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("r_wait", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000); expect_io("r_capture", 1'b1, 16'h0001, 1'b1, 1'b0);

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
